fp4_dot_mac: RTL and testbench

- Parametrised multi-lane FP4 (E2M1) multiply-accumulate engine; successor to the single-lane FP4 multiplier.
- Each accepted beat carries LANES operand pairs. Products are computed exactly, summed across lanes, and accumulated over a vector terminated by i_last.
- Emits one saturating fixed-point dot-product result per vector. Sits between the operand streamer and the requantiser.

---
 rtl/fp4_pkg.sv | 56 +++++
 rtl/fp4_lane_mul.sv | 28 ++
 rtl/fp4_dot_mac.sv | 156 +++++++++++++++
 tb/tb_fp4_dot_mac.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp4_pkg.sv
// fp4_pkg: shared types and helpers for the FP4 (E2M1) dot-product MAC.
//   fp4_t      - packed FP4 operand {sign, exp[1:0], man}
//   fp4_mag()  - unsigned magnitude in half units (value x2), 0..12
//   sat_add()  - signed add with clamp to a given two's-complement width
package fp4_pkg;

  typedef struct packed {
    logic       sign;
    logic [1:0] exp;
    logic       man;
  } fp4_t;

  // Signed lane product width: |qa*qb| <= 144 needs 8 magnitude bits plus sign.
  localparam int unsigned FP4_PROD_W = 9;

  typedef struct packed {
    logic               clamp;
    logic signed [31:0] val;
  } sat_res_t;

  // Magnitude x2 so the subnormal 0.5 stays an integer; products land in quarters.
  function automatic logic [3:0] fp4_mag(input fp4_t x);
    logic [3:0] q;
    case (x.exp)
      2'd0:    q = {3'b000, x.man};
      2'd1:    q = x.man ? 4'd3 : 4'd2;
      2'd2:    q = x.man ? 4'd6 : 4'd4;
      default: q = x.man ? 4'd12 : 4'd8;
    endcase
    return q;
  endfunction

  // Adds two sign-extended operands and clamps into [-2^(width-1), 2^(width-1)-1].
  function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                       input logic signed [31:0] b,
                                       input int unsigned        width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sat_res_t           r;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    r.clamp = 1'b1;
    if (sum > hi) begin
      r.val = hi[31:0];
    end else if (sum < lo) begin
      r.val = lo[31:0];
    end else begin
      r.clamp = 1'b0;
      r.val   = sum[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fp4_lane_mul.sv
// fp4_lane_mul: one FP4 lane, combinational decode and exact signed product.
//   a_i, b_i : FP4 operands {sign, exp[1:0], man}
//   prod_o   : signed product in quarter units (-144..144)
module fp4_lane_mul
  import fp4_pkg::*;
(
  input  logic [3:0]                   a_i,
  input  logic [3:0]                   b_i,
  output logic signed [FP4_PROD_W-1:0] prod_o
);

  fp4_t       a;
  fp4_t       b;
  logic [7:0] mag;

  always_comb begin
    a   = fp4_t'(a_i);
    b   = fp4_t'(b_i);
    mag = {4'b0000, fp4_mag(a)} * {4'b0000, fp4_mag(b)};
    // Negative zero has magnitude 0, so negating it still yields 0.
    if (a.sign ^ b.sign) begin
      prod_o = -$signed({1'b0, mag});
    end else begin
      prod_o = $signed({1'b0, mag});
    end
  end

endmodule

// File: rtl/fp4_dot_mac.sv
// fp4_dot_mac: LANES-wide FP4 multiply-accumulate with saturating vector result.
//   i_valid/o_ready/i_a/i_b/i_last : operand beat handshake, LANES FP4 pairs per beat
//   o_valid/i_ready/o_result/o_sat : one result per vector (i_last), quarter units
// Pipeline: accept register -> S1 lane products -> S2 lane sum -> S3 accumulate.
// Every stage advances together and freezes while a result is refused downstream.
module fp4_dot_mac
  import fp4_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [4*LANES-1:0]      i_a,
  input  logic [4*LANES-1:0]      i_b,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [ACC_W-1:0] o_result,
  output logic                    o_sat
);

  localparam int unsigned SUM_W = FP4_PROD_W + $clog2(LANES);

  logic advance;

  logic                  in_valid_q, in_valid_d, in_last_q, in_last_d;
  logic [4*LANES-1:0]    in_a_q, in_a_d, in_b_q, in_b_d;
  logic [LANES*FP4_PROD_W-1:0] lane_prod;
  logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [LANES*FP4_PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic                  s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic signed [SUM_W-1:0] s2_sum_q, s2_sum_d, lane_sum;
  logic signed [ACC_W-1:0] acc_q, acc_d, result_q, result_d, acc_next;
  logic                  sticky_q, sticky_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  sat_res_t              acc_res;

  assign advance  = !(out_valid_q && !i_ready);
  assign o_ready  = advance;
  assign o_valid  = out_valid_q;
  assign o_result = result_q;
  assign o_sat    = out_sat_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp4_lane_mul u_lane_mul (
      .a_i   (in_a_q[4*k +: 4]),
      .b_i   (in_b_q[4*k +: 4]),
      .prod_o(lane_prod[k*FP4_PROD_W +: FP4_PROD_W])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_W'($signed(s1_prod_q[k*FP4_PROD_W +: FP4_PROD_W]));
    end
  end

  always_comb begin
    acc_res  = sat_add(32'(acc_q), 32'(s2_sum_q), ACC_W);
    acc_next = acc_res.val[ACC_W-1:0];
  end

  // Front stages: capture on advance, hold otherwise.
  always_comb begin
    in_valid_d = in_valid_q;
    in_last_d  = in_last_q;
    in_a_d     = in_a_q;
    in_b_d     = in_b_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_prod_d  = s1_prod_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (advance) begin
      in_valid_d = i_valid;
      in_last_d  = i_last;
      in_a_d     = i_a;
      in_b_d     = i_b;
      s1_valid_d = in_valid_q;
      s1_last_d  = in_last_q;
      s1_prod_d  = lane_prod;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = lane_sum;
    end
  end

  // Accumulator and result register.
  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_sat_d   = out_sat_q;
    if (advance) begin
      // Not stalled, so any pending result is being taken this cycle.
      if (out_valid_q && i_ready) begin
        out_valid_d = 1'b0;
      end
      if (s2_valid_q) begin
        if (s2_last_q) begin
          // Loading a new result overrides the clear above: no bubble.
          out_valid_d = 1'b1;
          result_d    = acc_next;
          out_sat_d   = sticky_q | acc_res.clamp;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = acc_next;
          sticky_d = sticky_q | acc_res.clamp;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_valid_q  <= 1'b0;
      in_last_q   <= 1'b0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      in_valid_q  <= in_valid_d;
      in_last_q   <= in_last_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_sum_q    <= s2_sum_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fp4_dot_mac.sv
// tb_fp4_dot_mac: directed self-checking bench for fp4_dot_mac (LANES=4, ACC_W=12).
module tb_fp4_dot_mac;

  localparam int unsigned LANES = 4;
  localparam int unsigned ACC_W = 12;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b1;
  logic                    i_valid = 1'b0;
  logic                    i_last = 1'b0;
  logic                    i_ready = 1'b1;
  logic [4*LANES-1:0]      i_a = '0;
  logic [4*LANES-1:0]      i_b = '0;
  logic                    o_ready;
  logic                    o_valid;
  logic                    o_sat;
  logic signed [ACC_W-1:0] o_result;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic        q_last[$];
  int          q_res[$];
  int          q_sat[$];

  fp4_dot_mac #(
    .LANES(LANES),
    .ACC_W(ACC_W)
  ) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_sat   (o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    q_a.push_back(a);
    q_b.push_back(b);
    q_last.push_back(last);
  endtask

  task automatic push_exp(input int res, input int sat);
    q_res.push_back(res);
    q_sat.push_back(sat);
  endtask

  // Cycle loop, entered and left 1 time unit after a rising edge. i_ready is low
  // for cycles below rdy_from. first_cyc >= 0 demands result k at cycle first_cyc+k.
  task automatic run_stream(input string tag, input int rdy_from, input int first_cyc);
    int idx;
    int got;
    int cyc;
    logic stall_prev;
    logic signed [ACC_W-1:0] res_prev;
    idx = 0;
    got = 0;
    cyc = 0;
    stall_prev = 1'b0;
    res_prev = '0;
    while (got < q_res.size() && cyc < 200) begin
      i_ready = (cyc >= rdy_from);
      if (idx < q_a.size()) begin
        i_valid = 1'b1;
        i_a     = q_a[idx];
        i_b     = q_b[idx];
        i_last  = q_last[idx];
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check_eq({tag, "_hold_res"}, o_result, res_prev);
        check_eq({tag, "_hold_vld"}, o_valid, 1);
      end
      if (o_valid && !i_ready) check_eq({tag, "_stall_rdy"}, o_ready, 0);
      if (o_valid && i_ready) begin
        check_eq($sformatf("%s_res%0d", tag, got), o_result, q_res[got]);
        check_eq($sformatf("%s_sat%0d", tag, got), o_sat, q_sat[got]);
        if (first_cyc >= 0) check_eq($sformatf("%s_cyc%0d", tag, got), cyc, first_cyc + got);
        got++;
      end
      if (i_valid && o_ready) idx++;
      stall_prev = o_valid && !i_ready;
      res_prev   = o_result;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    if (got < q_res.size()) check_eq({tag, "_timeout"}, got, q_res.size());
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    check_eq({tag, "_drain"}, o_valid, 0);
    q_a.delete();
    q_b.delete();
    q_last.delete();
    q_res.delete();
    q_sat.delete();
  endtask

  initial begin
    // Reset
    #1 i_rst_n = 1'b0;
    #1;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_result", o_result, 0);
    check_eq("rst_sat", o_sat, 0);
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("rst_ready", o_ready, 1);

    // Single beat, 1.5 * -2.0 on lane0: o_valid exactly 3 edges after acceptance.
    i_a = 16'h0003; i_b = 16'h000C; i_last = 1'b1; i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_last = 1'b0;
    check_eq("lat_e0", o_valid, 0);
    @(posedge i_clk); #1;
    check_eq("lat_e1", o_valid, 0);
    @(posedge i_clk); #1;
    check_eq("lat_e2", o_valid, 0);
    @(posedge i_clk); #1;
    check_eq("lat_e3", o_valid, 1);
    check_eq("lat_res", o_result, -12);
    check_eq("lat_sat", o_sat, 0);
    @(posedge i_clk); #1;
    check_eq("lat_pop", o_valid, 0);

    // Subnormal 0.5*0.5 on all lanes, then negative zero: 1.0 total.
    push_beat(16'h1111, 16'h1111, 1'b0);
    push_beat(16'h8888, 16'h7777, 1'b1);
    push_exp(4, 0);
    run_stream("subn", 0, -1);

    // Positive saturation (4 x 576 > 2047), then a clean vector, then negative clamp.
    for (int k = 0; k < 4; k++) push_beat(16'h7777, 16'h7777, k == 3);
    push_exp(2047, 1);
    push_beat(16'h0002, 16'h0002, 1'b1);
    push_exp(4, 0);
    for (int k = 0; k < 4; k++) push_beat(16'hFFFF, 16'h7777, k == 3);
    push_exp(-2048, 1);
    run_stream("sat", 0, -1);

    // Back-to-back single-beat vectors at full rate.
    push_beat(16'h1234, 16'h4321, 1'b1); push_exp(20, 0);
    push_beat(16'h7654, 16'h1111, 1'b1); push_exp(30, 0);
    push_beat(16'h9ABC, 16'h1111, 1'b1); push_exp(-10, 0);
    push_beat(16'hF00F, 16'h700F, 1'b1); push_exp(0, 0);
    push_beat(16'h0077, 16'h0057, 1'b1); push_exp(216, 0);
    push_beat(16'h8888, 16'hFFFF, 1'b1); push_exp(0, 0);
    run_stream("b2b", 0, 4);

    // Back-pressure: downstream refuses until cycle 8 while beats keep coming.
    push_beat(16'h1234, 16'h4321, 1'b1); push_exp(20, 0);
    push_beat(16'h7654, 16'h1111, 1'b1); push_exp(30, 0);
    push_beat(16'h9ABC, 16'h1111, 1'b1); push_exp(-10, 0);
    push_beat(16'h0077, 16'h0057, 1'b1); push_exp(216, 0);
    push_beat(16'h0005, 16'h0005, 1'b1); push_exp(36, 0);
    run_stream("bp", 8, -1);

    // Reset mid-vector with a result pending.
    i_ready = 1'b0;
    i_a = 16'h1234; i_b = 16'h4321; i_last = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_a = 16'h7777; i_b = 16'h7777; i_last = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 8 && !o_valid; k++) begin
      @(posedge i_clk); #1;
    end
    check_eq("mid_pre_vld", o_valid, 1);
    check_eq("mid_pre_res", o_result, 20);
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", o_valid, 0);
    check_eq("mid_rst_res", o_result, 0);
    check_eq("mid_rst_sat", o_sat, 0);
    check_eq("mid_rst_rdy", o_ready, 1);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    push_beat(16'h0003, 16'h0003, 1'b0);
    push_beat(16'h0002, 16'h0002, 1'b1);
    push_exp(13, 0);
    run_stream("post", 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
